// File: rtl/xpb_accum_ctrl.sv
// xpb_accum_ctrl: walks the segments of a squarer upper word through one
// shared, registered xpb lookup table and accumulates the returned residue
// constants onto a base value. The result is handed off through a
// valid/ready output.
module xpb_accum_ctrl #(
  parameter  int WIDTH    = 1024,
  parameter  int SEG_BITS = 5,
  parameter  int NUM_SEG  = 8,
  parameter  int GUARD    = 4,
  localparam int SEL_W    = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1,
  localparam int ACC_W    = WIDTH + GUARD,
  localparam int UP_W     = NUM_SEG * SEG_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [UP_W-1:0]     in_upper,
  input  logic [ACC_W-1:0]    in_base,
  output logic [SEL_W-1:0]    xpb_sel,
  output logic [SEG_BITS-1:0] xpb_idx,
  input  logic [WIDTH-1:0]    xpb_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_W-1:0]    out_sum
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [UP_W-1:0]    upper_r;
  logic [SEL_W-1:0]   cnt_r;
  logic [ACC_W-1:0]   acc_r;
  logic               issued_d_r;   // a lookup was issued last cycle
  logic               accept_s;
  logic               last_seg_s;
  logic [SEG_BITS-1:0] seg_s;

  assign accept_s   = in_valid && (state_r == IDLE);
  assign last_seg_s = (cnt_r == SEL_W'(NUM_SEG - 1));
  assign seg_s      = upper_r[int'(cnt_r) * SEG_BITS +: SEG_BITS];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; DONE always returns through IDLE so a new request
  // cannot be taken in the same cycle as the output handshake.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (last_seg_s) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DRAIN: begin
        state_nxt_s = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Output decode from registered state only; lookup is driven solely in RUN.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    xpb_sel   = '0;
    xpb_idx   = '0;
    case (state_r)
      IDLE: begin
        in_ready = 1'b1;
      end
      RUN: begin
        xpb_sel = cnt_r;
        xpb_idx = seg_s;
      end
      DRAIN: begin
        in_ready = 1'b0;
      end
      DONE: begin
        out_valid = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign out_sum = acc_r;

  // Datapath: latch the operation, step the segment counter and accumulate
  // the table word that returns one cycle after each issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upper_r    <= '0;
      cnt_r      <= '0;
      acc_r      <= '0;
      issued_d_r <= 1'b0;
    end else begin
      issued_d_r <= (state_r == RUN);
      if (accept_s) begin
        upper_r <= in_upper;
        cnt_r   <= '0;
        acc_r   <= in_base;
      end else begin
        if (state_r == RUN) begin
          cnt_r <= cnt_r + SEL_W'(1);
        end else begin
          cnt_r <= cnt_r;
        end
        if (issued_d_r) begin
          acc_r <= acc_r + {{GUARD{1'b0}}, xpb_data};
        end else begin
          acc_r <= acc_r;
        end
      end
    end
  end

endmodule

// File: tb/tb_xpb_accum_ctrl.sv
// Self-checking bench for xpb_accum_ctrl with a registered model xpb table
// xpb[k][v] = 32*k + v and a scoreboard queue of expected sums.
module tb_xpb_accum_ctrl;

  localparam int WIDTH    = 16;
  localparam int SEG_BITS = 5;
  localparam int NUM_SEG  = 4;
  localparam int GUARD    = 3;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_upper;
  logic [18:0] in_base;
  logic [1:0]  xpb_sel;
  logic [4:0]  xpb_idx;
  logic [15:0] xpb_data;
  logic        out_valid;
  logic        out_ready;
  logic [18:0] out_sum;

  int n_tests = 0;
  int n_fail  = 0;

  logic [18:0] exp_q[$];
  int          lat;
  logic [7:0]  sels;
  logic [19:0] idxs;
  logic [18:0] got;
  logic [18:0] exp_v;

  xpb_accum_ctrl #(
    .WIDTH(WIDTH), .SEG_BITS(SEG_BITS), .NUM_SEG(NUM_SEG), .GUARD(GUARD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_upper(in_upper), .in_base(in_base),
    .xpb_sel(xpb_sel), .xpb_idx(xpb_idx), .xpb_data(xpb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered model lookup table.
  always_ff @(posedge clk) begin
    xpb_data <= 16'(xpb_sel) * 16'd32 + 16'(xpb_idx);
  end

  function automatic logic [18:0] model_sum(input logic [18:0] base, input logic [19:0] upper);
    logic [18:0] s;
    s = base;
    for (int k = 0; k < NUM_SEG; k++) begin
      s = s + 19'(32 * k) + 19'(upper[k*5 +: 5]);
    end
    return s;
  endfunction

  // Issue one request, scramble the inputs after acceptance, then wait
  // (bounded) for out_valid while recording the lookup select/index stream.
  task automatic run_op(input logic [18:0] base, input logic [19:0] upper);
    @(negedge clk);
    in_valid = 1'b1;
    in_base  = base;
    in_upper = upper;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_base  = 19'h7FFFF;
    in_upper = 20'($urandom);
    exp_q.push_back(model_sum(base, upper));
    lat  = 0;
    sels = 8'd0;
    idxs = 20'd0;
    while (!out_valid && lat < 20) begin
      if (lat < NUM_SEG) begin
        sels[lat*2 +: 2] = xpb_sel;
        idxs[lat*5 +: 5] = xpb_idx;
      end
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic pop_check(input string name);
    got = out_sum;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: out_sum=%h but scoreboard is empty", name, got);
    end else begin
      exp_v = exp_q.pop_front();
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL %s: out_sum=%h expected %h", name, got, exp_v);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_upper = 20'd0; in_base = 19'd0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({in_ready, out_valid, out_sum, xpb_sel, xpb_idx} !== {1'b1, 1'b0, 19'd0, 2'd0, 5'd0}) begin
      n_fail++;
      $display("FAIL reset: rdy=%b vld=%b sum=%h sel=%h idx=%h expected 1 0 0 0 0",
               in_ready, out_valid, out_sum, xpb_sel, xpb_idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_op(19'd0, 20'h08421);
    n_tests++;
    if (lat !== NUM_SEG + 1) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d edges expected %0d", lat, NUM_SEG + 1);
    end
    n_tests++;
    if (sels !== 8'b11_10_01_00) begin
      n_fail++;
      $display("FAIL basic_sel_seq: got %b expected 11100100", sels);
    end
    n_tests++;
    if (idxs !== 20'h08421) begin
      n_fail++;
      $display("FAIL basic_idx_seq: got %h expected 08421", idxs);
    end
    n_tests++;
    if (out_sum !== 19'd196) begin
      n_fail++;
      $display("FAIL basic_const: out_sum=%0d expected 196", out_sum);
    end
    pop_check("basic");
    @(posedge clk);
    #1;
    n_tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL basic_handshake: vld=%b rdy=%b expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_wrap();
    run_op(19'h7FFF0, 20'hF8000);
    n_tests++;
    if (out_sum !== 19'h000CF) begin
      n_fail++;
      $display("FAIL wrap_const: out_sum=%h expected 000cf", out_sum);
    end
    pop_check("wrap");
    @(posedge clk);
    #1;
  endtask

  task automatic test_zero();
    run_op(19'd7, 20'd0);
    n_tests++;
    if (lat !== NUM_SEG + 1) begin
      n_fail++;
      $display("FAIL zero_latency: got %0d edges expected %0d", lat, NUM_SEG + 1);
    end
    pop_check("zero");
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    logic [18:0] hold;
    out_ready = 1'b0;
    run_op(19'h12345, 20'hABCDE);
    hold = out_sum;
    pop_check("backpressure");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if ({out_valid, out_sum, in_ready, xpb_idx} !== {1'b1, hold, 1'b0, 5'd0}) begin
        n_fail++;
        $display("FAIL backpressure_hold[%0d]: vld=%b sum=%h rdy=%b idx=%h expected 1 %h 0 0",
                 i, out_valid, out_sum, in_ready, xpb_idx, hold);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL backpressure_release: vld=%b rdy=%b expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [18:0] base_b;
    logic [19:0] up_b;
    int          wait_n;
    base_b = 19'h00100;
    up_b   = 20'h5A5A5;
    @(negedge clk);
    in_valid = 1'b1;
    in_base  = 19'h0003C;
    in_upper = 20'h12345;
    @(posedge clk);
    #1;
    exp_q.push_back(model_sum(19'h0003C, 20'h12345));
    in_base  = base_b;
    in_upper = up_b;
    wait_n = 0;
    while (!out_valid && wait_n < 20) begin
      @(posedge clk);
      #1;
      wait_n++;
      n_tests++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_busy: in_ready=%b expected 0 while first op pending", in_ready);
      end
    end
    pop_check("b2b_first");
    @(posedge clk);
    #1;
    n_tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_gap: vld=%b rdy=%b expected 0 1 after handshake", out_valid, in_ready);
    end
    exp_q.push_back(model_sum(base_b, up_b));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second_accept: in_ready=%b expected 0", in_ready);
    end
    wait_n = 0;
    while (!out_valid && wait_n < 20) begin
      @(posedge clk);
      #1;
      wait_n++;
    end
    pop_check("b2b_second");
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    in_valid = 1'b1;
    in_base  = 19'h01234;
    in_upper = 20'hFFFFF;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp_q.push_back(model_sum(19'h01234, 20'hFFFFF));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    n_tests++;
    if ({out_valid, out_sum, in_ready, xpb_sel, xpb_idx} !== {1'b0, 19'd0, 1'b1, 2'd0, 5'd0}) begin
      n_fail++;
      $display("FAIL reset_mid_run: vld=%b sum=%h rdy=%b sel=%h idx=%h expected 0 0 1 0 0",
               out_valid, out_sum, in_ready, xpb_sel, xpb_idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(19'd5, 20'h10842);
    n_tests++;
    if (out_sum !== 19'd205) begin
      n_fail++;
      $display("FAIL after_reset_const: out_sum=%0d expected 205", out_sum);
    end
    pop_check("after_reset");
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_zero();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
